// File: rtl/scr_pkg.sv
// Shared geometry, control codes, state encoding and command decode for the
// character-stream screen writer.
package scr_pkg;

    localparam int         COLS   = 64;
    localparam int         ROWS   = 28;
    localparam int         ADDR_W = 11;
    localparam logic [7:0] BLANK  = 8'h20;

    localparam logic [7:0] CC_BS   = 8'h08;
    localparam logic [7:0] CC_LF   = 8'h0A;
    localparam logic [7:0] CC_HOME = 8'h0C;
    localparam logic [7:0] CC_CR   = 8'h0D;
    localparam logic [7:0] CC_CLS  = 8'h1F;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DECODE,
        ST_UNMARK,
        ST_PUT,
        ST_CLEAR,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_SCROLL_FILL,
        ST_MARK_RD,
        ST_MARK_WR
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_PUT,
        CMD_CR,
        CMD_LF,
        CMD_BS,
        CMD_HOME,
        CMD_CLS
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [7:0] b);
        cmd_t c;
        c = CMD_NONE;
        if (b >= 8'h20 && b <= 8'h7F) begin
            c = CMD_PUT;
        end else begin
            case (b)
                CC_CR:   c = CMD_CR;
                CC_LF:   c = CMD_LF;
                CC_BS:   c = CMD_BS;
                CC_HOME: c = CMD_HOME;
                CC_CLS:  c = CMD_CLS;
                default: c = CMD_NONE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/scr_writer_if.sv
// Byte-stream handshake plus synchronous screen-RAM port of the screen writer.
// The master modport is the writer's view; slave is the source/RAM side.
interface scr_writer_if #(
    parameter int ADDR_W = scr_pkg::ADDR_W
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic [7:0]        ram_rdata;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ram_addr,
        output ram_wdata,
        output ram_we,
        input  ram_rdata
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ram_addr,
        input  ram_wdata,
        input  ram_we,
        output ram_rdata
    );
endinterface

// File: rtl/scr_writer.sv
// Character-stream writer for the text screen RAM: cursor, control codes,
// clear and scroll. Define SCR_WRITER_CURSOR_EN to mark the cursor with bit 7.
module scr_writer
    import scr_pkg::*;
#(
    parameter int         COLS   = scr_pkg::COLS,
    parameter int         ROWS   = scr_pkg::ROWS,
    parameter int         ADDR_W = scr_pkg::ADDR_W,
    parameter logic [7:0] BLANK  = scr_pkg::BLANK
) (
    input  logic                    clk,
    input  logic                    reset,
    scr_writer_if.master            bus,
    output logic                    busy,
    output logic [$clog2(COLS)-1:0] cur_col,
    output logic [$clog2(ROWS)-1:0] cur_row
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(ROWS * COLS - 1);
    localparam logic [ADDR_W-1:0] SCROLL_LAST = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(COLS);

`ifdef SCR_WRITER_CURSOR_EN
    localparam state_t ST_POST = ST_MARK_RD;
`else
    localparam state_t ST_POST = ST_IDLE;
`endif

    state_t            r_state;
    logic [7:0]        r_byte;
    logic [ADDR_W-1:0] r_cnt;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_we;
    logic              r_copy;
`ifdef SCR_WRITER_CURSOR_EN
    logic              r_mark;
    logic [6:0]        r_shadow;
`endif

    cmd_t              w_cmd;
    state_t            w_disp_state;
    logic [COL_W-1:0]  w_disp_col;
    logic [ROW_W-1:0]  w_disp_row;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [7:0]        w_wdata;

    assign w_cmd      = decode_cmd(r_byte);
    assign w_cur_addr = ADDR_W'({r_row, r_col});

    // Where an accepted command goes next and how it moves the cursor.
    // Printable characters move the cursor later, in PUT.
    always_comb begin
        w_disp_state = ST_POST;
        w_disp_col   = r_col;
        w_disp_row   = r_row;
        case (w_cmd)
            CMD_PUT:  w_disp_state = ST_PUT;
            CMD_CR:   w_disp_col   = '0;
            CMD_LF: begin
                if (r_row == ROW_LAST) begin
                    w_disp_state = ST_SCROLL_RD;
                end else begin
                    w_disp_row = r_row + ROW_W'(1);
                end
            end
            CMD_BS: begin
                if (r_col != '0) begin
                    w_disp_col = r_col - COL_W'(1);
                end
            end
            CMD_HOME: begin
                w_disp_col = '0;
                w_disp_row = '0;
            end
            CMD_CLS:  w_disp_state = ST_CLEAR;
            default:  w_disp_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_byte  <= '0;
            r_cnt   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_copy  <= 1'b0;
`ifdef SCR_WRITER_CURSOR_EN
            r_mark   <= 1'b0;
            r_shadow <= BLANK[6:0];
`endif
        end else begin
            r_we   <= 1'b0;
            r_copy <= 1'b0;
`ifdef SCR_WRITER_CURSOR_EN
            r_mark <= 1'b0;
            // Read data arrives in the same cycle as the marking write.
            if (r_mark) begin
                r_shadow <= bus.ram_rdata[6:0];
            end
`endif
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_byte  <= bus.in_data;
                        r_state <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    if (w_cmd == CMD_NONE) begin
                        r_state <= ST_IDLE;
                    end else begin
`ifdef SCR_WRITER_CURSOR_EN
                        r_state <= ST_UNMARK;
`else
                        r_state <= w_disp_state;
                        r_col   <= w_disp_col;
                        r_row   <= w_disp_row;
                        r_cnt   <= '0;
`endif
                    end
                end

`ifdef SCR_WRITER_CURSOR_EN
                ST_UNMARK: begin
                    r_addr  <= w_cur_addr;
                    r_wdata <= {1'b0, r_shadow};
                    r_we    <= 1'b1;
                    r_state <= w_disp_state;
                    r_col   <= w_disp_col;
                    r_row   <= w_disp_row;
                    r_cnt   <= '0;
                end
`endif

                ST_PUT: begin
                    r_addr  <= w_cur_addr;
                    r_wdata <= {1'b0, r_byte[6:0]};
                    r_we    <= 1'b1;
                    if (r_col == COL_LAST) begin
                        r_col <= '0;
                        if (r_row == ROW_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_SCROLL_RD;
                        end else begin
                            r_row   <= r_row + ROW_W'(1);
                            r_state <= ST_POST;
                        end
                    end else begin
                        r_col   <= r_col + COL_W'(1);
                        r_state <= ST_POST;
                    end
                end

                ST_CLEAR: begin
                    r_addr  <= r_cnt;
                    r_wdata <= BLANK;
                    r_we    <= 1'b1;
                    if (r_cnt == SCREEN_LAST) begin
                        r_cnt   <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= ST_POST;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end

                ST_SCROLL_RD: begin
                    r_addr  <= r_cnt + ROW_STRIDE;
                    r_state <= ST_SCROLL_WR;
                end

                // The read issued one cycle earlier returns while this write
                // is on the bus, so the data is forwarded from ram_rdata.
                ST_SCROLL_WR: begin
                    r_addr  <= r_cnt;
                    r_we    <= 1'b1;
                    r_copy  <= 1'b1;
                    r_cnt   <= r_cnt + ADDR_W'(1);
                    r_state <= (r_cnt == SCROLL_LAST) ? ST_SCROLL_FILL : ST_SCROLL_RD;
                end

                ST_SCROLL_FILL: begin
                    r_addr  <= r_cnt;
                    r_wdata <= BLANK;
                    r_we    <= 1'b1;
                    if (r_cnt == SCREEN_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_POST;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end

`ifdef SCR_WRITER_CURSOR_EN
                ST_MARK_RD: begin
                    r_addr  <= w_cur_addr;
                    r_state <= ST_MARK_WR;
                end

                ST_MARK_WR: begin
                    r_addr  <= w_cur_addr;
                    r_we    <= 1'b1;
                    r_mark  <= 1'b1;
                    r_state <= ST_IDLE;
                end
`endif

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_wdata = r_wdata;
        if (r_copy) begin
            w_wdata = bus.ram_rdata;
        end
`ifdef SCR_WRITER_CURSOR_EN
        if (r_mark) begin
            w_wdata = {1'b1, bus.ram_rdata[6:0]};
        end
`endif
    end

    assign bus.ram_addr  = r_addr;
    assign bus.ram_we    = r_we;
    assign bus.ram_wdata = w_wdata;
    assign bus.in_ready  = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign cur_col       = r_col;
    assign cur_row       = r_row;

endmodule

// File: tb/tb_scr_writer.sv
// Randomized self-checking bench for scr_writer against a screen-array model
// with a synchronous RAM behind the writer's bus.
module tb_scr_writer;

    localparam int COLS   = 64;
    localparam int ROWS   = 28;
    localparam int ADDR_W = 11;
    localparam int CELLS  = COLS * ROWS;
    localparam int LIMIT  = 20000;
`ifdef SCR_WRITER_CURSOR_EN
    localparam int CUR_EN = 1;
`else
    localparam int CUR_EN = 0;
`endif

    logic       clk;
    logic       reset;
    logic       busy;
    logic [5:0] cur_col;
    logic [4:0] cur_row;
    logic       scramble;

    logic [7:0] mem [0:(1 << ADDR_W) - 1];
    logic [7:0] scr [0:CELLS - 1];
    int         mrow;
    int         mcol;
    int         checks;
    int         errors;
    int         wr_total;
    int         wr_blank;
    int         acc_cnt;
    int         tx_num;

    scr_writer_if #(.ADDR_W(ADDR_W)) bus ();

    scr_writer dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .cur_col (cur_col),
        .cur_row (cur_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous screen RAM: data for an address appears one cycle later.
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < CELLS; i++) mem[i] <= 8'($urandom);
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    always @(posedge clk) begin
        if (bus.ram_we) begin
            wr_total++;
            if (bus.ram_wdata == 8'h20) wr_blank++;
        end
        if (bus.in_valid && bus.in_ready) acc_cnt++;
    end

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int a = 0; a < CELLS; a++) scr[a] = 8'h20;
        mrow = 0;
        mcol = 0;
    endfunction

    function automatic void model_lf();
        if (mrow == ROWS - 1) begin
            for (int a = 0; a < CELLS - COLS; a++) scr[a] = scr[a + COLS];
            for (int a = CELLS - COLS; a < CELLS; a++) scr[a] = 8'h20;
        end else begin
            mrow++;
        end
    endfunction

    function automatic void model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7F) begin
            scr[mrow * COLS + mcol] = b;
            if (mcol == COLS - 1) begin
                mcol = 0;
                model_lf();
            end else begin
                mcol++;
            end
        end else if (b == 8'h0D) mcol = 0;
        else if (b == 8'h0A) model_lf();
        else if (b == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (b == 8'h0C) begin
            mrow = 0;
            mcol = 0;
        end else if (b == 8'h1F) model_clear();
    endfunction

    function automatic logic [7:0] exp_cell(input int a);
        logic [7:0] v;
        v = scr[a];
        if (CUR_EN != 0 && a == mrow * COLS + mcol) v[7] = 1'b1;
        return v;
    endfunction

    function automatic int first_diff();
        for (int a = 0; a < CELLS; a++) begin
            if (mem[a] !== exp_cell(a)) return a;
        end
        return -1;
    endfunction

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32, 127));
    endfunction

    // ---------------- driver ----------------
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: in_ready=%b after %0d cycles, required 1", tag, bus.in_ready, n);
        end
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready("send_pre");
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        model_apply(b);
        wait_ready("send_done");
        @(negedge clk);
        tx_num++;
        $display("tx %0d: data=%02h -> row=%0d col=%0d", tx_num, b, cur_row, cur_col);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int t0, b0, bad;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset    = 1'b1;
        scramble = 1'b1;
        @(negedge clk);
        scramble = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", bus.in_ready); end
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b required 1", busy); end
        if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b required 0", bus.ram_we); end
        if (bus.ram_addr !== 11'd0) begin errors++; $display("FAIL reset_ram_addr: got %0d required 0", bus.ram_addr); end
        if (bus.ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_ram_wdata: got %02h required 00", bus.ram_wdata); end
        if (cur_col !== 6'd0) begin errors++; $display("FAIL reset_cur_col: got %0d required 0", cur_col); end
        if (cur_row !== 5'd0) begin errors++; $display("FAIL reset_cur_row: got %0d required 0", cur_row); end
        // Let a clear run partway, then abort it with a second reset.
        reset = 1'b0;
        repeat (200) @(negedge clk);
        reset    = 1'b1;
        scramble = 1'b1;
        @(negedge clk);
        scramble = 1'b0;
        reset    = 1'b0;
        t0 = wr_total;
        b0 = wr_blank;
        model_clear();
        wait_ready("reset_clear");
        @(negedge clk);
        checks += 3;
        if (wr_blank - b0 != 1792) begin errors++; $display("FAIL reset_blank_writes: got %0d required 1792", wr_blank - b0); end
        if (wr_total - t0 != 1792 + CUR_EN) begin errors++; $display("FAIL reset_total_writes: got %0d required %0d", wr_total - t0, 1792 + CUR_EN); end
        bad = first_diff();
        if (bad !== -1) begin errors++; $display("FAIL reset_screen: addr %0d is %02h required %02h", bad, mem[bad], exp_cell(bad)); end
`ifdef SCR_WRITER_CURSOR_EN
        checks++;
        if (mem[0] !== 8'hA0) begin errors++; $display("FAIL reset_cursor_cell: got %02h required a0", mem[0]); end
`endif
    endtask

    task automatic test_char();
        int bad;
        send(8'h41);
        checks += 4;
        if (mem[0] !== 8'h41) begin errors++; $display("FAIL char_cell0: got %02h required 41", mem[0]); end
        if (cur_col !== 6'd1) begin errors++; $display("FAIL char_col: got %0d required 1", cur_col); end
        if (cur_row !== 5'd0) begin errors++; $display("FAIL char_row: got %0d required 0", cur_row); end
        bad = first_diff();
        if (bad !== -1) begin errors++; $display("FAIL char_screen: addr %0d is %02h required %02h", bad, mem[bad], exp_cell(bad)); end
`ifdef SCR_WRITER_CURSOR_EN
        checks++;
        if (mem[1] !== 8'hA0) begin errors++; $display("FAIL char_cursor_cell: got %02h required a0", mem[1]); end
`endif
    endtask

    task automatic test_wrap();
        int bad;
        for (int i = 0; i < 63; i++) send(8'h42);
        send(8'h43);
        checks += 4;
        if (mem[64] !== 8'h43) begin errors++; $display("FAIL wrap_cell64: got %02h required 43", mem[64]); end
        if (cur_row !== 5'd1) begin errors++; $display("FAIL wrap_row: got %0d required 1", cur_row); end
        if (cur_col !== 6'd1) begin errors++; $display("FAIL wrap_col: got %0d required 1", cur_col); end
        bad = first_diff();
        if (bad !== -1) begin errors++; $display("FAIL wrap_screen: addr %0d is %02h required %02h", bad, mem[bad], exp_cell(bad)); end
    endtask

    task automatic test_bs_cr();
        int bad;
        send(8'h0D);
        send(8'h08);
        checks++;
        if (cur_col !== 6'd0) begin errors++; $display("FAIL bs_at_col0: got %0d required 0", cur_col); end
        for (int i = 0; i < 5; i++) send(rand_print());
        send(8'h08);
        checks += 2;
        if (cur_col !== 6'd4) begin errors++; $display("FAIL bs_col: got %0d required 4", cur_col); end
        bad = first_diff();
        if (bad !== -1) begin errors++; $display("FAIL bs_screen: addr %0d is %02h required %02h", bad, mem[bad], exp_cell(bad)); end
        send(8'h0D);
        checks += 2;
        if (cur_col !== 6'd0) begin errors++; $display("FAIL cr_col: got %0d required 0", cur_col); end
        bad = first_diff();
        if (bad !== -1) begin errors++; $display("FAIL cr_screen: addr %0d is %02h required %02h", bad, mem[bad], exp_cell(bad)); end
    endtask

    task automatic test_scroll();
        int         bad, n, blank_bad;
        logic [7:0] old64;
        n = 0;
        while (mrow != ROWS - 1 && n < 3000) begin
            send(rand_print());
            n++;
        end
        for (int i = 0; i < 3; i++) send(rand_print());
        old64 = scr[64];
        send(8'h0A);
        blank_bad = 0;
        for (int a = CELLS - COLS; a < CELLS; a++) begin
            if ((mem[a] & 8'h7F) !== 8'h20) blank_bad++;
        end
        checks += 5;
        if (mem[0] !== old64) begin errors++; $display("FAIL scroll_cell0: got %02h required %02h", mem[0], old64); end
        if (cur_row !== 5'd27) begin errors++; $display("FAIL scroll_row: got %0d required 27", cur_row); end
        if (cur_col !== 6'd3) begin errors++; $display("FAIL scroll_col: got %0d required 3", cur_col); end
        if (blank_bad != 0) begin errors++; $display("FAIL scroll_last_row: %0d cells not 20, required 0", blank_bad); end
        bad = first_diff();
        if (bad !== -1) begin errors++; $display("FAIL scroll_screen: addr %0d is %02h required %02h", bad, mem[bad], exp_cell(bad)); end
    endtask

    task automatic test_last_cell();
        int         bad;
        logic [7:0] c;
        while (mcol != COLS - 1) send(rand_print());
        c = rand_print();
        send(c);
        checks += 4;
        if (mem[1727] !== c) begin errors++; $display("FAIL lastcell_moved: got %02h required %02h", mem[1727], c); end
        if (cur_row !== 5'd27) begin errors++; $display("FAIL lastcell_row: got %0d required 27", cur_row); end
        if (cur_col !== 6'd0) begin errors++; $display("FAIL lastcell_col: got %0d required 0", cur_col); end
        bad = first_diff();
        if (bad !== -1) begin errors++; $display("FAIL lastcell_screen: addr %0d is %02h required %02h", bad, mem[bad], exp_cell(bad)); end
    endtask

    task automatic test_random();
        int         bad, r;
        logic [7:0] b;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) b = rand_print();
            else if (r < 76) b = 8'h0D;
            else if (r < 80) b = 8'h08;
            else if (r < 83) b = 8'h0C;
            else if (r < 87) b = 8'h0A;
            else if (r < 88) b = 8'h1F;
            else begin
                do begin
                    b = 8'($urandom_range(0, 255));
                end while ((b >= 8'h20 && b <= 8'h7F) || b == 8'h08 || b == 8'h0A ||
                           b == 8'h0C || b == 8'h0D || b == 8'h1F);
            end
            send(b);
            checks++;
            if ({cur_row, cur_col} !== {5'(mrow), 6'(mcol)}) begin
                errors++;
                $display("FAIL random_cursor: byte %02h got row %0d col %0d required row %0d col %0d",
                         b, cur_row, cur_col, mrow, mcol);
            end
        end
        checks++;
        bad = first_diff();
        if (bad !== -1) begin errors++; $display("FAIL random_screen: addr %0d is %02h required %02h", bad, mem[bad], exp_cell(bad)); end
    endtask

    task automatic test_cls_busy();
        int a0, bad;
        send(8'h0C);
        for (int i = 0; i < 10; i++) send(rand_print());
        send(8'h0A);
        wait_ready("cls_pre");
        a0 = acc_cnt;
        bus.in_data  = 8'h1F;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_data = 8'h5A;
        wait_ready("cls_busy");
        bus.in_valid = 1'b0;
        model_apply(8'h1F);
        @(negedge clk);
        $display("tx %0d: data=1f (valid held) -> row=%0d col=%0d", ++tx_num, cur_row, cur_col);
        checks += 4;
        if (acc_cnt - a0 != 1) begin errors++; $display("FAIL cls_accepts: got %0d required 1", acc_cnt - a0); end
        if (cur_row !== 5'd0) begin errors++; $display("FAIL cls_row: got %0d required 0", cur_row); end
        if (cur_col !== 6'd0) begin errors++; $display("FAIL cls_col: got %0d required 0", cur_col); end
        bad = first_diff();
        if (bad !== -1) begin errors++; $display("FAIL cls_screen: addr %0d is %02h required %02h", bad, mem[bad], exp_cell(bad)); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        wr_total = 0;
        wr_blank = 0;
        acc_cnt  = 0;
        tx_num   = 0;
        scramble = 1'b0;
        reset    = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_char();
        test_wrap();
        test_bs_cr();
        test_scroll();
        test_last_cell();
        test_random();
        test_cls_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
